register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter NREG, default 32: number of registers; power of two, at least 2.
REQ-002 Parameter NRD, default 2: number of read ports.
REQ-003 Parameter NWR, default 2: number of write ports.
REQ-004 Parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding.
REQ-005 CLK  in  1  clock; all state updates on rising edge.
REQ-006 RST  in  1  reset; asynchronous, active-high.
REQ-007 wen  in  NWR  per-port write enable.
REQ-008 wsel  in  NWR x log2(NREG)  per-port write register index.
REQ-009 wdat  in  NWR x WORD_W  per-port write data.
REQ-010 rsel  in  NRD x log2(NREG)  per-port read register index.
REQ-011 rdat  out  NRD x WORD_W  per-port read data.
REQ-012 rbusy  out  NRD  scoreboard busy bit of each rsel register.
REQ-013 issue_en  in  1  marks register issue_sel as pending.
REQ-014 issue_sel  in  log2(NREG)  register to mark busy.
REQ-015 clr_req  in  1  one-cycle pulse requesting a full-file clear.
REQ-016 clr_busy  out  1  high while a clear sweep is in progress.

Function
REQ-017 Register 0 reads 0 and is never busy; writes and issues to index 0 are discarded.
REQ-018 A write with wen[i]=1 updates register wsel[i] at the next rising edge.
REQ-019 If several ports write the same register in one cycle, the highest-numbered port wins.
REQ-020 Reads are combinational: rdat[j] equals stored register rsel[j].
REQ-021 With BYPASS=1, if any enabled write targets rsel[j] in the current cycle, rdat[j] equals that write's wdat (highest-numbered matching port); register 0 is never bypassed.
REQ-022 With BYPASS=0, rdat[j] returns the old value in the write cycle and the new value from the next cycle.
REQ-023 Scoreboard: issue_en sets busy[issue_sel] at the next edge; any enabled write to a register clears its busy bit at the next edge.
REQ-024 An issue and a write to the same register in the same cycle leave busy set.
REQ-025 rbusy[j] equals busy[rsel[j]] combinationally; there is no bypass on busy.
REQ-026 Controller states: IDLE and CLEAR; reset enters IDLE.
REQ-027 In IDLE, clr_req moves the controller to CLEAR, sets the sweep counter to 1, and clears all busy bits at the same edge.
REQ-028 In CLEAR, each cycle zeroes register[counter] and increments the counter; after register NREG-1 is zeroed the controller returns to IDLE.
REQ-029 clr_busy is high exactly during the NREG-1 CLEAR cycles.
REQ-030 In CLEAR, writes, issues and further clr_req are ignored; reads return current stored values with no bypass.
REQ-031 The sweep counter is log2(NREG) bits wide and never wraps past NREG-1.

Reset
REQ-032 RST asserted: all registers 0, all busy bits 0, state IDLE, counter 0, clr_busy 0, independent of CLK.
REQ-033 RST asserted mid-sweep aborts the sweep immediately; after release the block is in IDLE and accepts writes on the first edge.

Structure
REQ-034 WORD_W, the word_t typedef and the clear-controller state enum live in the shared cpu_types_pkg; NREG, NRD and NWR are module parameters.
REQ-035 The write-port priority resolution is one sub-module, rf_wr_arbiter, instantiated once per register.

Verification
REQ-036 Write 0xDEADBEEF to reg 5 on port 0; next cycle read reg 5 on both ports -> 0xDEADBEEF on both.
REQ-037 BYPASS=1: same cycle, port 0 writes 0x11 and port 1 writes 0x22 to reg 7 while rsel[0]=7 -> rdat[0]=0x22 in that cycle and reg 7=0x22 afterwards.
REQ-038 Write 0xFFFF to reg 0 and issue reg 0 -> rdat=0 and rbusy=0.
REQ-039 Issue reg 3 -> rbusy=1 next cycle; write reg 3 plus issue reg 3 in one cycle -> rbusy stays 1; write only -> rbusy=0.
REQ-040 Fill all registers, pulse clr_req -> clr_busy high for NREG-1 cycles, a write during the sweep is dropped, all registers read 0 afterwards.
REQ-041 Assert RST at sweep cycle 10 -> clr_busy=0 immediately and all registers 0; a write on the first edge after release succeeds.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, word type and the clear-controller
// state encoding used by the register file.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    CTRL_IDLE  = 1'b0,
    CTRL_CLEAR = 1'b1
  } clr_state_t;

endpackage : cpu_types_pkg

// File: rtl/rf_wr_arbiter.sv
// Write-port priority resolver for one register of the file. It reports
// whether any enabled port targets this register and, if so, the data of the
// highest-numbered such port. Register 0 is hard-wired: it never reports a hit.
module rf_wr_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NWR = 2,
  parameter int AW  = 5,
  parameter int IDX = 0
) (
  input  logic [NWR-1:0]             wen,
  input  logic [NWR-1:0][AW-1:0]     wsel,
  input  logic [NWR-1:0][WORD_W-1:0] wdat,
  output logic                       hit,
  output word_t                      dat
);

  localparam logic [AW-1:0] IDX_SEL = AW'(IDX);
  localparam logic          LIVE    = (IDX != 0);

  logic [NWR-1:0] match;

  for (genvar i = 0; i < NWR; i++) begin : g_match
    assign match[i] = LIVE & wen[i] & (wsel[i] == IDX_SEL);
  end

  // Scan ports low to high so a later (higher-numbered) match overrides.
  always_comb begin
    hit = 1'b0;
    dat = '0;
    for (int i = 0; i < NWR; i++) begin
      hit = hit | match[i];
      dat = match[i] ? word_t'(wdat[i]) : dat;
    end
  end

endmodule : rf_wr_arbiter

// File: rtl/register_file_mp.sv
// Multi-port register file with a per-register busy scoreboard and a
// sequential clear controller. Register 0 is a constant zero. During a clear
// sweep the file is frozen against writes and issues; reads see stored data.
module register_file_mp
  import cpu_types_pkg::*;
#(
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NWR-1:0]             wen,
  input  logic [NWR-1:0][AW-1:0]     wsel,
  input  logic [NWR-1:0][WORD_W-1:0] wdat,
  input  logic [NRD-1:0][AW-1:0]     rsel,
  output logic [NRD-1:0][WORD_W-1:0] rdat,
  output logic [NRD-1:0]             rbusy,
  input  logic                       issue_en,
  input  logic [AW-1:0]              issue_sel,
  input  logic                       clr_req,
  output logic                       clr_busy
);

  word_t           regs    [NREG];
  logic [NREG-1:0] busy;
  clr_state_t      state;
  logic [AW-1:0]   cnt;

  logic [NREG-1:0] wr_take;
  word_t           wr_dat  [NREG];
  logic [NREG-1:0] issue_mask;
  logic            accept;

  assign accept = (state == CTRL_IDLE);

  for (genvar r = 0; r < NREG; r++) begin : g_arb
    rf_wr_arbiter #(
      .NWR (NWR),
      .AW  (AW),
      .IDX (r)
    ) u_arb (
      .wen  (wen),
      .wsel (wsel),
      .wdat (wdat),
      .hit  (wr_take[r]),
      .dat  (wr_dat[r])
    );
  end

  // One-hot busy set request from the issue port; index 0 is never tracked.
  always_comb begin
    issue_mask = '0;
    if (issue_en && (issue_sel != '0)) begin
      issue_mask[issue_sel] = 1'b1;
    end else begin
      issue_mask = '0;
    end
  end

  // Register storage: normal writes in IDLE, one register zeroed per CLEAR cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (state == CTRL_CLEAR) begin
      regs[cnt] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_take[r]) begin
          regs[r] <= wr_dat[r];
        end
      end
    end
  end

  // Clear controller and busy scoreboard. A same-cycle issue wins over the
  // write-clear because the set is ORed in after the clear mask.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= CTRL_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      busy     <= '0;
    end else begin
      case (state)
        CTRL_IDLE: begin
          if (clr_req) begin
            state    <= CTRL_CLEAR;
            cnt      <= AW'(1);
            clr_busy <= 1'b1;
            busy     <= '0;
          end else begin
            busy <= (busy & ~wr_take) | issue_mask;
          end
        end
        CTRL_CLEAR: begin
          if (cnt == AW'(NREG - 1)) begin
            state    <= CTRL_IDLE;
            clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          state    <= CTRL_IDLE;
          cnt      <= '0;
          clr_busy <= 1'b0;
          busy     <= '0;
        end
      endcase
    end
  end

  // Combinational read ports with optional write forwarding while IDLE.
  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      if ((BYPASS != 0) && accept && wr_take[rsel[j]]) begin
        rdat[j] = wr_dat[rsel[j]];
      end else begin
        rdat[j] = regs[rsel[j]];
      end
      rbusy[j] = busy[rsel[j]];
    end
  end

endmodule : register_file_mp
